// File: rtl/ctrl_pipe_stage.sv
// Control-bundle pipeline register between RV32I stages: DEPTH entries with
// valid bits, stall/flush handling, occupancy and a saturating flush counter.
module ctrl_pipe_stage #(
    parameter int unsigned            WIDTH        = 20,
    parameter int unsigned            DEPTH        = 1,
    parameter logic [WIDTH-1:0]       BUBBLE_VALUE = '0,
    parameter int unsigned            CNT_W        = 16,
    localparam int unsigned           OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] ctrl_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] ctrl_out,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] flush_count
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] ctrl_q [DEPTH];
    logic [WIDTH-1:0] ctrl_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Next-state: flush beats stall beats advance; Clear is applied in the register.
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        flush_cnt_d = flush_cnt_q;
        occ_d       = '0;

        if (Flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = BUBBLE_VALUE;
            end
            if ((|valid_q) && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (!Stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
            end
            valid_d[0] = valid_in;
            ctrl_d[0]  = valid_in ? ctrl_in : BUBBLE_VALUE;
        end

        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            valid_q     <= '0;
            occ_q       <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= BUBBLE_VALUE;
            end
        end else begin
            valid_q     <= valid_d;
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
        end
    end

    assign valid_out   = valid_q[DEPTH-1];
    assign ctrl_out    = ctrl_q[DEPTH-1];
    assign occupancy   = occ_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Directed bench for ctrl_pipe_stage: a DEPTH=2 instance checked through an
// output scoreboard, plus a CNT_W=2 instance for counter saturation.
module tb_ctrl_pipe_stage;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Main instance: WIDTH=20, DEPTH=2, CNT_W=16
    logic        clear, stall, flush, valid_in;
    logic [19:0] ctrl_in;
    logic        valid_out;
    logic [19:0] ctrl_out;
    logic [1:0]  occupancy;
    logic [15:0] flush_count;

    // Saturation instance: CNT_W=2
    logic        s_clear, s_stall, s_flush, s_valid_in;
    logic [19:0] s_ctrl_in;
    logic        s_valid_out;
    logic [19:0] s_ctrl_out;
    logic [1:0]  s_occupancy;
    logic [1:0]  s_flush_count;

    ctrl_pipe_stage #(.WIDTH(20), .DEPTH(2), .BUBBLE_VALUE(20'h0), .CNT_W(16)) dut (
        .Clk(Clk), .Clear(clear), .Stall(stall), .Flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in),
        .valid_out(valid_out), .ctrl_out(ctrl_out),
        .occupancy(occupancy), .flush_count(flush_count)
    );

    ctrl_pipe_stage #(.WIDTH(20), .DEPTH(2), .BUBBLE_VALUE(20'h0), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Clear(s_clear), .Stall(s_stall), .Flush(s_flush),
        .valid_in(s_valid_in), .ctrl_in(s_ctrl_in),
        .valid_out(s_valid_out), .ctrl_out(s_ctrl_out),
        .occupancy(s_occupancy), .flush_count(s_flush_count)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic st, input logic fl,
                         input logic vi, input logic [19:0] ci);
        clear    = clr;
        stall    = st;
        flush    = fl;
        valid_in = vi;
        ctrl_in  = ci;
    endtask

    // One clock: update the scoreboard from what is driven, then check the output.
    task automatic tick();
        logic        hold;
        logic [31:0] exp;
        hold = !clear && !flush && stall;
        if (clear || flush) exp_q.delete();
        else if (!stall && valid_in) exp_q.push_back(32'(ctrl_in));
        @(posedge Clk);
        #1;
        if (valid_out) begin
            if (hold) exp = last_out;
            else if (exp_q.size() == 0) exp = 32'hDEAD_BEEF;
            else exp = exp_q.pop_front();
            chk("sb_ctrl_out", 32'(ctrl_out), exp);
            last_out = exp;
        end else begin
            chk("bubble_ctrl_out", 32'(ctrl_out), 32'h0);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 20'hFFFFF);
        s_clear = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_valid_in = 1'b0; s_ctrl_in = '0;

        // Reset
        @(posedge Clk); #1;
        tick(); tick();
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_ctrl_out", 32'(ctrl_out), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_flush_count", 32'(flush_count), 32'h0);

        // Streaming 1,2,3 then A5A5A, 5A5A5
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00001); tick();
        chk("stream_occ1", 32'(occupancy), 32'd1);
        chk("stream_lat_vo", 32'(valid_out), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00002); tick();
        chk("stream_occ2", 32'(occupancy), 32'd2);
        chk("stream_out1", 32'(ctrl_out), 32'h00001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h00003); tick();
        chk("stream_occ3", 32'(occupancy), 32'd2);
        chk("stream_out2", 32'(ctrl_out), 32'h00002);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'hA5A5A); tick();
        chk("stream_occ4", 32'(occupancy), 32'd2);
        chk("stream_out3", 32'(ctrl_out), 32'h00003);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h5A5A5); tick();
        chk("load_out_a5", 32'(ctrl_out), 32'hA5A5A);

        // Stall 3 cycles with a value upstream that must never appear
        drive(1'b0, 1'b1, 1'b0, 1'b1, 20'h12345);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ctrl_out", 32'(ctrl_out), 32'hA5A5A);
            chk("stall_valid_out", 32'(valid_out), 32'h1);
            chk("stall_occupancy", 32'(occupancy), 32'd2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20'h00000); tick();
        chk("stall_release_out", 32'(ctrl_out), 32'h5A5A5);
        chk("stall_release_occ", 32'(occupancy), 32'd1);

        // Fill, then Stall+Flush together
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h0ABCD); tick();
        chk("fill_vo", 32'(valid_out), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h0BEEF); tick();
        chk("fill_occ", 32'(occupancy), 32'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 20'h77777); tick();
        chk("flush_vo", 32'(valid_out), 32'h0);
        chk("flush_ctrl", 32'(ctrl_out), 32'h0);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_cnt1", 32'(flush_count), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 20'h00000); tick();
        chk("flush_empty_cnt", 32'(flush_count), 32'd1);
        chk("flush_empty_occ", 32'(occupancy), 32'd0);

        // Bubble gating
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20'hFFFFF); tick();
        chk("bubble_occ", 32'(occupancy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20'h00000); tick();
        chk("bubble_out", 32'(ctrl_out), 32'h0);
        chk("bubble_vo", 32'(valid_out), 32'h0);

        // Clear mid-stream, then accept on the first edge after it drops
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h11111); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h22222); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 20'h33333); tick();
        chk("clr_mid_vo", 32'(valid_out), 32'h0);
        chk("clr_mid_occ", 32'(occupancy), 32'd0);
        chk("clr_mid_cnt", 32'(flush_count), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 20'h44444); tick();
        chk("post_clr_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20'h00000); tick();
        chk("post_clr_out", 32'(ctrl_out), 32'h44444);
        chk("post_clr_vo", 32'(valid_out), 32'h1);
        tick();
        chk("drain_vo", 32'(valid_out), 32'h0);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        // Counter saturation on the CNT_W=2 instance
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        chk("sat_rst", 32'(s_flush_count), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            s_valid_in = 1'b1; s_ctrl_in = 20'(k); tick();
            s_valid_in = 1'b0; s_flush = 1'b1;     tick();
            s_flush = 1'b0;
            chk($sformatf("sat_cnt%0d", k), 32'(s_flush_count), (k < 3) ? 32'(k) : 32'd3);
            chk("sat_occ", 32'(s_occupancy), 32'd0);
        end
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        chk("sat_clear", 32'(s_flush_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_stage.md
Name: ctrl_pipe_stage

Overview:
- Parametrised control-bundle pipeline register that carries decoded control signals between RV32I pipeline stages (D->E, E->M, M->W).
- Generalises the per-bit flip-flop control registers into one block with:
  - configurable bundle width and stage depth;
  - a per-entry valid bit;
  - stall (hold) and flush (bubble insertion);
  - an occupancy count and a flush event counter for hazard-unit debug.
- Invalid entries always present BUBBLE_VALUE on the control outputs, so regwrite/memwrite can never fire from a bubble.

Parameters:
- WIDTH, 20, width of the control bundle (regwrite, memwrite, jump/branch/jalr, result_src, load_sel, store_sel, alu_control, alu_srca, alu_srcb packed by the instantiator).
- DEPTH, 1, number of register stages in series (1..8).
- BUBBLE_VALUE, 0 (WIDTH bits), control value held by any entry whose valid bit is 0.
- CNT_W, 16, width of the saturating flush event counter.

Ports:
- Clk          input   1             rising-edge clock
- Clear        input   1             synchronous active-high reset
- Stall        input   1             hold all stages this cycle
- Flush        input   1             kill all in-flight entries this cycle
- valid_in     input   1             ctrl_in carries a real instruction
- ctrl_in      input   WIDTH         control bundle from the upstream stage
- valid_out    output  1             valid bit of the last stage
- ctrl_out     output  WIDTH         control bundle of the last stage
- occupancy    output  clog2(DEPTH+1)  number of valid entries in the pipe
- flush_count  output  CNT_W         flushes that killed >=1 valid entry, saturating

Behaviour:
- State: DEPTH entries {valid[i], ctrl[i]}. Entry 0 is the input side; entry DEPTH-1 drives ctrl_out and valid_out. All state updates occur on the rising edge of Clk.
- Priority each cycle, highest first:
  - Clear: all valid[i]=0, all ctrl[i]=BUBBLE_VALUE, flush_count=0.
  - Flush: all valid[i]=0, all ctrl[i]=BUBBLE_VALUE. flush_count increments (saturating) iff at least one valid[i]=1 before the edge. Flush overrides Stall; valid_in in the same cycle is discarded.
  - Stall: every entry holds its value; valid_in/ctrl_in are ignored (the upstream stage holds them).
  - Advance: entry i takes entry i-1 for i>=1. Entry 0 takes {1, ctrl_in} if valid_in=1, else {0, BUBBLE_VALUE}.
- Invariant: valid[i]=0 implies ctrl[i]=BUBBLE_VALUE, in all states, including after Clear.
- Latency: DEPTH cycles from valid_in/ctrl_in sampled to valid_out/ctrl_out, with no stalls. Each Stall cycle adds exactly one cycle. Throughput is one entry per cycle.
- Outputs are purely registered; there is no combinational path from any input to any output.
- occupancy: registered count of set valid bits, updated on the same edge as the entries. Range is 0..DEPTH. It is 0 after Clear or Flush.
- flush_count: holds at 2^CNT_W-1 once saturated. It is cleared only by Clear.
- Reset values: valid_out=0, ctrl_out=BUBBLE_VALUE, occupancy=0, flush_count=0.
- Clear asserted mid-stream discards all entries. The pipe accepts new input on the first edge after Clear deasserts.
- DEPTH=1 is functionally identical to a plain register with clear, plus the valid, stall, flush and counter features.
- Simultaneous Stall+Flush behaves as Flush. Simultaneous Clear+anything behaves as Clear.

Test Plan:
- Reset: WIDTH=20, DEPTH=2, BUBBLE_VALUE=0; assert Clear 2 cycles with valid_in=1, ctrl_in=20'hFFFFF -> valid_out=0, ctrl_out=0, occupancy=0, flush_count=0.
- Streaming: drive ctrl_in=20'h00001, 20'h00002, 20'h00003 with valid_in=1 on consecutive cycles -> ctrl_out shows 1, 2, 3 starting exactly 2 edges later; occupancy reads 1, 2, 2, 2.
- Stall: load 20'hA5A5A then 20'h5A5A5, then assert Stall 3 cycles while ctrl_in=20'h12345 -> outputs frozen for 3 cycles; 20'h12345 is never observed; latency of the 20'h5A5A5 entry is 2+3 edges.
- Flush vs stall: with a full pipe, assert Stall=1 and Flush=1 together -> next edge valid_out=0, ctrl_out=0, occupancy=0, flush_count=1. Flush on an already empty pipe -> flush_count stays 1.
- Bubble gating: valid_in=0 with ctrl_in=20'hFFFFF -> ctrl_out=0 two edges later (regwrite/memwrite bits low).
- Counter saturation: CNT_W=2; perform 5 flushes, each on a pipe holding >=1 valid entry -> flush_count reads 1, 2, 3, 3, 3. Clear -> 0.
